// File: rtl/conv_layer_scheduler_pkg.sv
// Shared definitions for the convolution layer scheduler: FSM encoding and
// helpers that derive padded-frame geometry from the image width.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Padded frame edge length (one zero border on every side).
  function automatic int unsigned pad_w(input int unsigned w);
    return w + 2;
  endfunction

  function automatic int unsigned npix(input int unsigned w);
    return w * w;
  endfunction

  // Width of a per-filter output counter able to hold npix(w).
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w * w + 1);
  endfunction

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Layer-level bus of the scheduler: controller handshake, frame RAM read port
// and the shared filter input bus with per-filter valid returns.
interface conv_layer_scheduler_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned NUM_FILTERS = 16
);

  logic                      start;
  logic                      pause;
  logic                      mem_rd_en;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [3*DATA_WIDTH-1:0]   mem_rd_data;
  logic [3*DATA_WIDTH-1:0]   pix_data;
  logic                      pix_wren;
  logic [NUM_FILTERS-1:0]    filt_valid;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    input  start, pause, mem_rd_data, filt_valid,
    output mem_rd_en, mem_addr, pix_data, pix_wren, busy, done, err
  );

  modport slave (
    output start, pause, mem_rd_data, filt_valid,
    input  mem_rd_en, mem_addr, pix_data, pix_wren, busy, done, err
  );

endinterface

// File: rtl/conv_layer_scheduler_raster.sv
// Raster walker over the zero-padded frame: row/col position plus the
// row-major address of the unpadded image, advanced one position per enable.
module padded_raster_counter
  import conv_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  interior,
  output logic                  last
);

  localparam int unsigned PW   = pad_w(WIDTH);
  localparam int unsigned RC_W = $clog2(PW);
  localparam logic [RC_W-1:0] LAST_RC = RC_W'(PW - 1);
  localparam logic [RC_W-1:0] MAX_IN  = RC_W'(WIDTH);

  logic [RC_W-1:0] row;
  logic [RC_W-1:0] col;

  always_comb begin
    interior = (row != '0) && (row <= MAX_IN) && (col != '0) && (col <= MAX_IN);
    last     = (row == LAST_RC) && (col == LAST_RC);
  end

  // The interior address only advances on interior positions, so it follows
  // row-major order of the unpadded image without a multiplier.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (en) begin
      if (interior) addr <= addr + 1'b1;
      if (col == LAST_RC) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Convolution layer scheduler: streams a zero-padded frame from the RGB frame
// RAM to all filter blocks and counts each filter's outputs to detect completion.
module conv_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_FILTERS = 16,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input logic                    clk,
  input logic                    rst,
  conv_layer_scheduler_if.master bus
);

  localparam int unsigned NPIX  = npix(WIDTH);
  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NPIX);

  state_t state;
  state_t next;

  logic                    accept;
  logic                    issue;
  logic                    counting;
  logic                    interior;
  logic                    last;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    emit_vld;
  logic                    emit_int;
  logic                    err_q;
  logic                    over;
  logic                    all_full;
  logic [NUM_FILTERS-1:0]  full;
  logic [CNT_W-1:0]        cnt [NUM_FILTERS];
  logic [3*DATA_WIDTH-1:0] rd_word;

  assign accept   = (state == S_IDLE) && bus.start;
  assign issue    = (state == S_STREAM) && !bus.pause;
  assign counting = (state == S_STREAM) || (state == S_DRAIN);
  assign rd_word  = bus.mem_rd_data;

  padded_raster_counter #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (issue),
    .addr     (addr),
    .interior (interior),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   if (bus.start)      next = S_STREAM;
      S_STREAM: if (issue && last)  next = S_DRAIN;
      S_DRAIN:  if (all_full)       next = S_DONE;
      S_DONE:                       next = S_IDLE;
      default:                      next = S_IDLE;
    endcase
  end

  // Emit stage: RAM data arrives one cycle after the read, so the issue
  // decision is delayed by one register to line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      emit_vld <= 1'b0;
      emit_int <= 1'b0;
    end else begin
      emit_vld <= issue;
      emit_int <= issue && interior;
    end
  end

  always_comb begin
    full = '0;
    over = 1'b0;
    for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
      full[i] = (cnt[i] == CNT_FULL);
      if (counting && bus.filt_valid[i] && full[i]) over = 1'b1;
    end
    all_full = &full;
  end

  always_ff @(posedge clk) begin
    if (!rst || accept) begin
      for (int unsigned i = 0; i < NUM_FILTERS; i++) cnt[i] <= '0;
      err_q <= 1'b0;
    end else if (counting) begin
      for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
        if (bus.filt_valid[i] && !full[i]) cnt[i] <= cnt[i] + 1'b1;
      end
      if (over) err_q <= 1'b1;
    end
  end

  assign bus.mem_rd_en = issue && interior;
  assign bus.mem_addr  = addr;
  assign bus.pix_wren  = emit_vld;
  assign bus.pix_data  = emit_int ? rd_word : '0;
  assign bus.busy      = counting;
  assign bus.done      = (state == S_DONE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler at WIDTH=4, NUM_FILTERS=2 with a
// one-cycle-latency RAM model whose word i carries {i+0x300, i+0x200, i}.
module tb_conv_layer_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NF = 2;
  localparam logic [3*DW-1:0] JUNK = {3{32'hDEADBEEF}};

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   n_done;
  logic [3*DW-1:0] wq[$];
  int              wcyc[$];
  logic [AW-1:0]   aq[$];

  conv_layer_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_FILTERS(NF)) bus ();

  conv_layer_scheduler #(
    .DATA_WIDTH  (DW),
    .WIDTH       (4),
    .NUM_FILTERS (NF),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3*DW-1:0] word(input int unsigned i);
    logic [31:0] v;
    v = i;
    return {v + 32'h300, v + 32'h200, v};
  endfunction

  function automatic logic [3*DW-1:0] exp_pix(input int k);
    int r;
    int c;
    r = k / 6;
    c = k % 6;
    if (r >= 1 && r <= 4 && c >= 1 && c <= 4) return word((r - 1) * 4 + (c - 1));
    return '0;
  endfunction

  always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? word(int'(bus.mem_addr)) : JUNK;

  initial begin
    cyc = 0;
    n_done = 0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.pix_wren) begin
      wq.push_back(bus.pix_data);
      wcyc.push_back(cyc);
    end
    if (bus.mem_rd_en) aq.push_back(bus.mem_addr);
    if (bus.done) n_done = n_done + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_pix(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wq.size() >= n) break;
      @(negedge clk);
    end
    if (wq.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_valids(input logic [NF-1:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.filt_valid = mask;
    end
    tick();
    bus.filt_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    vectors++; if (bus.pix_wren !== 1'b0) begin miscompares++; $display("FAIL reset_pix_wren got %b want 0", bus.pix_wren); end
    vectors++; if (bus.mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd_en got %b want 0", bus.mem_rd_en); end
    vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    vectors++; if (bus.pix_data !== '0) begin miscompares++; $display("FAIL reset_pix_data got %h want 0", bus.pix_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err); end
    rst = 1'b1;
    repeat (2) tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_stream();
    int base, abase, dbase;
    bit ok;
    base = wq.size(); abase = aq.size(); dbase = n_done;
    pulse_start();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL stream_busy got %b want 1", bus.busy); end
    wait_pix(base + 36, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stream_timeout got %0d pulses want 36", wq.size() - base); end
    repeat (4) tick();
    vectors++; if (wq.size() - base !== 36) begin miscompares++; $display("FAIL stream_count got %0d want 36", wq.size() - base); end
    vectors++; if (wcyc[base + 35] - wcyc[base] !== 35) begin miscompares++; $display("FAIL stream_span got %0d want 35", wcyc[base + 35] - wcyc[base]); end
    for (int k = 0; k < 36; k++) begin
      vectors++; if (wq[base + k] !== exp_pix(k)) begin miscompares++; $display("FAIL stream_pix[%0d] got %h want %h", k, wq[base + k], exp_pix(k)); end
    end
    vectors++; if (aq.size() - abase !== 16) begin miscompares++; $display("FAIL stream_reads got %0d want 16", aq.size() - abase); end
    for (int k = 0; k < 16; k++) begin
      vectors++; if (aq[abase + k] !== AW'(k)) begin miscompares++; $display("FAIL stream_addr[%0d] got %0d want %0d", k, aq[abase + k], k); end
    end
    send_valids(2'b11, 16);
    wait_done(50, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stream_done got 0 want 1"); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL stream_busy_at_done got %b want 0", bus.busy); end
    tick();
    vectors++; if (n_done - dbase !== 1) begin miscompares++; $display("FAIL stream_done_count got %0d want 1", n_done - dbase); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL stream_err got %b want 0", bus.err); end
  endtask

  task automatic test_pause();
    int base, dbase;
    bit ok;
    base = wq.size(); dbase = n_done;
    pulse_start();
    repeat (10) tick();
    bus.pause = 1'b1;
    repeat (3) tick();
    bus.pause = 1'b0;
    wait_pix(base + 36, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL pause_timeout got %0d pulses want 36", wq.size() - base); end
    repeat (4) tick();
    vectors++; if (wq.size() - base !== 36) begin miscompares++; $display("FAIL pause_count got %0d want 36", wq.size() - base); end
    vectors++; if (wcyc[base + 10] - wcyc[base + 9] !== 4) begin miscompares++; $display("FAIL pause_gap got %0d want 4", wcyc[base + 10] - wcyc[base + 9]); end
    vectors++; if (wcyc[base + 35] - wcyc[base] !== 38) begin miscompares++; $display("FAIL pause_span got %0d want 38", wcyc[base + 35] - wcyc[base]); end
    for (int k = 0; k < 36; k++) begin
      vectors++; if (wq[base + k] !== exp_pix(k)) begin miscompares++; $display("FAIL pause_pix[%0d] got %h want %h", k, wq[base + k], exp_pix(k)); end
    end
    send_valids(2'b11, 16);
    wait_done(50, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL pause_done got 0 want 1"); end
    tick();
  endtask

  task automatic test_lag();
    int base, dbase;
    bit ok;
    base = wq.size(); dbase = n_done;
    pulse_start();
    wait_pix(base + 36, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL lag_timeout got %0d pulses want 36", wq.size() - base); end
    for (int t = 0; t < 36; t++) begin
      tick();
      bus.filt_valid[0] = (t < 16);
      bus.filt_valid[1] = (t >= 20);
    end
    vectors++; if (bus.busy !== 1'b1 || n_done != dbase) begin miscompares++; $display("FAIL lag_drain_hold got busy=%b dones=%0d want busy=1 dones=0", bus.busy, n_done - dbase); end
    tick();
    bus.filt_valid = '0;
    vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL lag_last_valid got done=%b busy=%b want 0/1", bus.done, bus.busy); end
    tick();
    vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL lag_done got done=%b busy=%b want 1/0", bus.done, bus.busy); end
    tick();
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL lag_done_width got %b want 0", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL lag_err got %b want 0", bus.err); end
  endtask

  task automatic test_restart_ignored();
    int base, dbase;
    bit ok;
    base = wq.size(); dbase = n_done;
    pulse_start();
    wait_pix(base + 10, 200, ok);
    pulse_start();
    wait_pix(base + 36, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL restart_timeout got %0d pulses want 36", wq.size() - base); end
    pulse_start();
    send_valids(2'b11, 16);
    wait_done(50, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL restart_done got 0 want 1"); end
    repeat (6) tick();
    vectors++; if (wq.size() - base !== 36) begin miscompares++; $display("FAIL restart_count got %0d want 36", wq.size() - base); end
    vectors++; if (n_done - dbase !== 1) begin miscompares++; $display("FAIL restart_done_count got %0d want 1", n_done - dbase); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL restart_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_err();
    int base;
    bit ok;
    base = wq.size();
    pulse_start();
    wait_pix(base + 36, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL err_timeout got %0d pulses want 36", wq.size() - base); end
    send_valids(2'b01, 16);
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_at_full got %b want 0", bus.err); end
    send_valids(2'b01, 1);
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL err_overflow got %b want 1", bus.err); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL err_busy got %b want 1", bus.busy); end
    send_valids(2'b10, 16);
    wait_done(50, ok);
    vectors++; if (!ok || bus.err !== 1'b1) begin miscompares++; $display("FAIL err_at_done got done_seen=%b err=%b want 1/1", ok, bus.err); end
    repeat (3) tick();
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", bus.err); end
    base = wq.size();
    pulse_start();
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b want 0", bus.err); end
    wait_pix(base + 36, 200, ok);
    send_valids(2'b11, 16);
    wait_done(50, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL err_frame2_done got 0 want 1"); end
    tick();
  endtask

  task automatic test_mid_reset();
    int base, abase, n;
    bit ok;
    base = wq.size();
    pulse_start();
    wait_pix(base + 20, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_timeout got %0d pulses want 20", wq.size() - base); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++; if (bus.pix_wren !== 1'b0) begin miscompares++; $display("FAIL midrst_pix_wren got %b want 0", bus.pix_wren); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    vectors++; if (bus.mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL midrst_rd_en got %b want 0", bus.mem_rd_en); end
    n = wq.size();
    repeat (3) tick();
    vectors++; if (wq.size() !== n) begin miscompares++; $display("FAIL midrst_idle_pulses got %0d want 0", wq.size() - n); end
    base = wq.size(); abase = aq.size();
    pulse_start();
    wait_pix(base + 36, 200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_refill got %0d pulses want 36", wq.size() - base); end
    repeat (3) tick();
    for (int k = 0; k < 36; k++) begin
      vectors++; if (wq[base + k] !== exp_pix(k)) begin miscompares++; $display("FAIL midrst_pix[%0d] got %h want %h", k, wq[base + k], exp_pix(k)); end
    end
    vectors++; if (aq.size() - abase !== 16) begin miscompares++; $display("FAIL midrst_reads got %0d want 16", aq.size() - abase); end
    vectors++; if (aq[abase] !== '0 || aq[abase + 15] !== 4'd15) begin miscompares++; $display("FAIL midrst_addr got %0d..%0d want 0..15", aq[abase], aq[abase + 15]); end
    send_valids(2'b11, 16);
    wait_done(50, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_done got 0 want 1"); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.filt_valid = '0;
    test_reset();
    test_stream();
    test_pause();
    test_lag();
    test_restart_ignored();
    test_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
